// File: rtl/apb_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_gpio_pkg
// Description : Shared defaults and APB phase encoding for the APB-to-GPIO
//               front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_gpio_pkg;

    localparam int c_addr_w = 32;
    localparam int c_data_w = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_phase_t;

endpackage : apb_gpio_pkg
`default_nettype wire

// File: rtl/apb_gpio_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_gpio_if
// Description : Zero-wait-state APB3 slave bridging to a GPIO core register
//               port; supplies the core clock/reset and registers its IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_gpio_if
    import apb_gpio_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] gpio_dat_o,
    input  logic              gpio_int_o,
    output logic              PREADY,
    output logic [DATA_W-1:0] PRDATA,
    output logic              IRQ,
    output logic              sys_clk,
    output logic              sys_rst,
    output logic              gpio_we,
    output logic [ADDR_W-1:0] gpio_addr,
    output logic [DATA_W-1:0] gpio_dat_i
);

    logic       w_setup;
    logic       w_access;
    logic       w_proto_err;
    logic       r_irq;
    apb_phase_t r_state;
    apb_phase_t w_state_next;

    assign w_setup  = PSEL & ~PENABLE;
    assign w_access = PSEL & PENABLE;

    assign sys_clk    = PCLK;
    assign sys_rst    = ~PRESETn;
    assign gpio_addr  = PADDR;
    assign gpio_dat_i = PWDATA;

    // Qualifying with PRESETn lets a reset abort an access without a clock edge.
    assign PREADY  = w_access & PRESETn;
    assign gpio_we = w_access & PWRITE & PRESETn;
    assign PRDATA  = (w_access & ~PWRITE & PRESETn) ? gpio_dat_o : '0;
    assign IRQ     = r_irq;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= gpio_int_o;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Phase tracker is observational only; it never gates the datapath.
    always_comb begin
        w_state_next = r_state;
        w_proto_err  = PENABLE & (r_state == IDLE);
        if (!PSEL) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_setup)  w_state_next = SETUP;
                SETUP:   if (w_access) w_state_next = ACCESS;
                ACCESS:  if (w_setup)  w_state_next = SETUP;
                default: w_state_next = IDLE;
            endcase
        end
    end

    a_no_proto_err : assert property (@(posedge PCLK) disable iff (!PRESETn) !w_proto_err);

endmodule : apb_gpio_if
`default_nettype wire

// File: tb/tb_apb_gpio_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_gpio_if
// Description : Self-checking bench for apb_gpio_if: vector table for the
//               per-cycle datapath, queue scoreboard for core writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_gpio_if;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] gpio_dat_o;
    logic          gpio_int_o;
    logic          PREADY;
    logic [DW-1:0] PRDATA;
    logic          IRQ, sys_clk, sys_rst, gpio_we;
    logic [AW-1:0] gpio_addr;
    logic [DW-1:0] gpio_dat_i;

    apb_gpio_if #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .gpio_dat_o (gpio_dat_o),
        .gpio_int_o (gpio_int_o),
        .PREADY     (PREADY),
        .PRDATA     (PRDATA),
        .IRQ        (IRQ),
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .gpio_we    (gpio_we),
        .gpio_addr  (gpio_addr),
        .gpio_dat_i (gpio_dat_i)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic          psel, penable, pwrite;
        logic [AW-1:0] paddr;
        logic [DW-1:0] pwdata;
        logic [DW-1:0] dat_o;
        logic          exp_ready, exp_we;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];
    wr_t  obs_q[$];
    vec_t vecs[15];

    // Write monitor: everything the core would capture on this edge.
    always @(posedge PCLK) begin
        if (gpio_we === 1'b1) obs_q.push_back('{gpio_addr, gpio_dat_i});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drain();
        wr_t o, e;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                check("unexpected_write", {o.addr, o.data}, 64'h0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", o.addr, e.addr);
                check("wr_data", o.data, e.data);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, 0, 0, 32'h0,         32'h0,     32'h0,         0, 0, 32'h0};
        vecs[1]  = '{1, 0, 1, 32'hFFFF_0F0F, 32'd201,   32'h0,         0, 0, 32'h0};
        vecs[2]  = '{1, 1, 1, 32'hFFFF_0F0F, 32'd201,   32'h0,         1, 1, 32'h0};
        vecs[3]  = '{0, 0, 0, 32'h0,         32'h0,     32'h0,         0, 0, 32'h0};
        vecs[4]  = '{1, 0, 0, 32'hF0F0_FFFF, 32'h0,     32'd201,       0, 0, 32'h0};
        vecs[5]  = '{1, 1, 0, 32'hF0F0_FFFF, 32'h0,     32'd201,       1, 0, 32'd201};
        vecs[6]  = '{0, 0, 0, 32'hF0F0_FFFF, 32'h0,     32'd201,       0, 0, 32'h0};
        vecs[7]  = '{1, 0, 1, 32'h0000_0010, 32'hA5A5,  32'h0,         0, 0, 32'h0};
        vecs[8]  = '{1, 1, 1, 32'h0000_0010, 32'hA5A5,  32'h0,         1, 1, 32'h0};
        vecs[9]  = '{1, 0, 0, 32'h0000_0014, 32'h0,     32'hDEAD_BEEF, 0, 0, 32'h0};
        vecs[10] = '{1, 1, 0, 32'h0000_0014, 32'h0,     32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF};
        vecs[11] = '{1, 0, 1, 32'h0000_0018, 32'h1234,  32'h5555_5555, 0, 0, 32'h0};
        vecs[12] = '{1, 1, 1, 32'h0000_0018, 32'h1234,  32'h5555_5555, 1, 1, 32'h0};
        vecs[13] = '{1, 1, 1, 32'h0000_001C, 32'h9876,  32'h5555_5555, 1, 1, 32'h0};
        vecs[14] = '{0, 0, 0, 'x,            'x,        32'h7777_7777, 0, 0, 32'h0};

        // Reset with an access-looking bus and a pending interrupt.
        PRESETn = 0; PSEL = 1; PENABLE = 1; PWRITE = 1;
        PADDR = 32'h1; PWDATA = 32'h2; gpio_dat_o = 32'hCAFE_F00D; gpio_int_o = 1;
        repeat (2) @(posedge PCLK);
        #1;
        check("rst_pready", PREADY, 0);
        check("rst_we", gpio_we, 0);
        check("rst_prdata_wr", PRDATA, 0);
        check("rst_irq", IRQ, 0);
        check("rst_sys_rst", sys_rst, 1);
        check("rst_sys_clk_hi", sys_clk, PCLK);
        PWRITE = 0;
        #1;
        check("rst_prdata_rd", PRDATA, 0);
        @(negedge PCLK);
        check("rst_sys_clk_lo", sys_clk, PCLK);
        PSEL = 0; PENABLE = 0; PWRITE = 0; gpio_int_o = 0;
        #2 PRESETn = 1;
        #1 check("rel_sys_rst", sys_rst, 0);

        // Table-driven single-cycle vectors; a write access queues the expected capture.
        for (int i = 0; i < 15; i++) begin
            @(posedge PCLK);
            #1;
            drain();
            PSEL = vecs[i].psel; PENABLE = vecs[i].penable; PWRITE = vecs[i].pwrite;
            PADDR = vecs[i].paddr; PWDATA = vecs[i].pwdata; gpio_dat_o = vecs[i].dat_o;
            if (vecs[i].exp_we) exp_q.push_back('{vecs[i].paddr, vecs[i].pwdata});
            #3;
            check($sformatf("v%0d_pready", i), PREADY, vecs[i].exp_ready);
            check($sformatf("v%0d_we", i), gpio_we, vecs[i].exp_we);
            check($sformatf("v%0d_prdata", i), PRDATA, vecs[i].exp_rdata);
            if (vecs[i].psel) begin
                check($sformatf("v%0d_addr", i), gpio_addr, vecs[i].paddr);
                check($sformatf("v%0d_wdata", i), gpio_dat_i, vecs[i].pwdata);
            end
            check($sformatf("v%0d_proto_err", i), dut.w_proto_err, 0);
        end
        @(posedge PCLK);
        #1;
        drain();
        check("writes_pending", exp_q.size(), 0);

        // IRQ follows the level with one edge of latency.
        #5 gpio_int_o = 1;
        #1 check("irq_before_edge", IRQ, 0);
        @(posedge PCLK);
        #1 check("irq_rise", IRQ, 1);
        #4 gpio_int_o = 0;
        #1 check("irq_hold", IRQ, 1);
        @(posedge PCLK);
        #1 check("irq_fall", IRQ, 0);

        // Reset mid-access: strobes drop immediately and the write never lands.
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'hABCD_0000; PWDATA = 32'h0BAD;
        gpio_int_o = 1;
        @(posedge PCLK);
        #1 PENABLE = 1;
        #2;
        check("abort_we_pre", gpio_we, 1);
        check("abort_ready_pre", PREADY, 1);
        check("abort_irq_pre", IRQ, 1);
        #1 PRESETn = 0;
        #1;
        check("abort_we", gpio_we, 0);
        check("abort_ready", PREADY, 0);
        check("abort_irq", IRQ, 0);
        check("abort_sys_rst", sys_rst, 1);
        @(posedge PCLK);
        #1 drain();
        PSEL = 0; PENABLE = 0; PWRITE = 0; gpio_int_o = 0;
        @(posedge PCLK);
        #1 PRESETn = 1;

        // Recovery: a read right after reset release.
        @(posedge PCLK);
        #1 PSEL = 1; PADDR = 32'h20; gpio_dat_o = 32'h1357_9BDF;
        @(posedge PCLK);
        #1 PENABLE = 1;
        #2;
        check("post_rst_prdata", PRDATA, 32'h1357_9BDF);
        check("post_rst_ready", PREADY, 1);
        check("post_rst_proto", dut.w_proto_err, 0);
        @(posedge PCLK);
        #1 PSEL = 0; PENABLE = 0;
        drain();
        #2 check("post_rst_prdata_idle", PRDATA, 0);
        check("no_stray_writes", obs_q.size() + exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_apb_gpio_if
`default_nettype wire
